// File: rtl/grant_finish_unit.sv
// Grant finish unit: forwards grant beats unchanged and queues one finish
// message per completed grant that needs one, stalling grants when the queue is full.
module grant_finish_unit #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned BEATS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_in_grant_valid,
    output logic        io_in_grant_ready,
    input  logic [2:0]  io_in_grant_bits_addr_beat,
    input  logic [1:0]  io_in_grant_bits_client_xact_id,
    input  logic        io_in_grant_bits_manager_xact_id,
    input  logic        io_in_grant_bits_is_builtin_type,
    input  logic [3:0]  io_in_grant_bits_g_type,
    input  logic [63:0] io_in_grant_bits_data,
    input  logic        io_in_grant_bits_manager_id,
    output logic        io_out_grant_valid,
    input  logic        io_out_grant_ready,
    output logic [2:0]  io_out_grant_bits_addr_beat,
    output logic [1:0]  io_out_grant_bits_client_xact_id,
    output logic        io_out_grant_bits_manager_xact_id,
    output logic        io_out_grant_bits_is_builtin_type,
    output logic [3:0]  io_out_grant_bits_g_type,
    output logic [63:0] io_out_grant_bits_data,
    output logic        io_out_grant_bits_manager_id,
    output logic        io_finish_valid,
    input  logic        io_finish_ready,
    output logic        io_finish_bits_manager_xact_id,
    output logic        io_finish_bits_manager_id,
    output logic        io_busy
);

    localparam int unsigned CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned NW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
    localparam logic [PW-1:0] PTR_MAX   = PW'(DEPTH - 1);
    localparam logic [NW-1:0] FULL_CNT  = NW'(DEPTH);

    logic [CW-1:0] beat_cnt;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [NW-1:0] count;
    logic [1:0]    entries [DEPTH];

    logic multibeat;
    logic needs_finish;
    logic last_beat;
    logic full;
    logic stall;
    logic fire;
    logic enq;
    logic deq;

    // Grant payload is a zero-latency pass-through
    assign io_out_grant_bits_addr_beat       = io_in_grant_bits_addr_beat;
    assign io_out_grant_bits_client_xact_id  = io_in_grant_bits_client_xact_id;
    assign io_out_grant_bits_manager_xact_id = io_in_grant_bits_manager_xact_id;
    assign io_out_grant_bits_is_builtin_type = io_in_grant_bits_is_builtin_type;
    assign io_out_grant_bits_g_type          = io_in_grant_bits_g_type;
    assign io_out_grant_bits_data            = io_in_grant_bits_data;
    assign io_out_grant_bits_manager_id      = io_in_grant_bits_manager_id;

    assign multibeat = (!io_in_grant_bits_is_builtin_type && (io_in_grant_bits_g_type <= 4'd1)) ||
                       ( io_in_grant_bits_is_builtin_type && (io_in_grant_bits_g_type == 4'd5));
    assign needs_finish = !io_in_grant_bits_is_builtin_type || (io_in_grant_bits_g_type != 4'd0);
    assign last_beat    = !multibeat || (beat_cnt == LAST_BEAT);
    assign full         = (count == FULL_CNT);

    // Stall looks only at the registered count, so a same-cycle dequeue cannot lift it
    assign stall = !reset && needs_finish && last_beat && full;

    assign io_out_grant_valid = io_in_grant_valid && !stall;
    assign io_in_grant_ready  = io_out_grant_ready && !stall;
    assign fire               = io_in_grant_valid && io_in_grant_ready;

    assign io_finish_valid                = !reset && (count != '0);
    assign io_finish_bits_manager_xact_id = entries[rd_ptr][1];
    assign io_finish_bits_manager_id      = entries[rd_ptr][0];
    assign io_busy                        = !reset && ((beat_cnt != '0) || (count != '0));

    assign enq = fire && needs_finish && last_beat;
    assign deq = io_finish_valid && io_finish_ready;

    // Beat counter tracks position within a multibeat burst only
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt <= '0;
        end else if (fire && multibeat) begin
            beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + PW'(1);
            end
            if (deq) begin
                rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + PW'(1);
            end
            if (enq && !deq) begin
                count <= count + NW'(1);
            end else if (deq && !enq) begin
                count <= count - NW'(1);
            end
        end
    end

    // Finish payload storage needs no reset; validity comes from count
    always_ff @(posedge clk) begin
        if (enq) begin
            entries[wr_ptr] <= {io_in_grant_bits_manager_xact_id, io_in_grant_bits_manager_id};
        end
    end

endmodule

// File: tb/tb_grant_finish_unit.sv
// Randomized and directed bench for grant_finish_unit against a queue-based
// transaction model of grants, bursts and pending finish messages.
module tb_grant_finish_unit;

    localparam int DEPTH = 2;
    localparam int BEATS = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        io_in_grant_valid;
    logic        io_in_grant_ready;
    logic [2:0]  io_in_grant_bits_addr_beat;
    logic [1:0]  io_in_grant_bits_client_xact_id;
    logic        io_in_grant_bits_manager_xact_id;
    logic        io_in_grant_bits_is_builtin_type;
    logic [3:0]  io_in_grant_bits_g_type;
    logic [63:0] io_in_grant_bits_data;
    logic        io_in_grant_bits_manager_id;
    logic        io_out_grant_valid;
    logic        io_out_grant_ready;
    logic [2:0]  io_out_grant_bits_addr_beat;
    logic [1:0]  io_out_grant_bits_client_xact_id;
    logic        io_out_grant_bits_manager_xact_id;
    logic        io_out_grant_bits_is_builtin_type;
    logic [3:0]  io_out_grant_bits_g_type;
    logic [63:0] io_out_grant_bits_data;
    logic        io_out_grant_bits_manager_id;
    logic        io_finish_valid;
    logic        io_finish_ready;
    logic        io_finish_bits_manager_xact_id;
    logic        io_finish_bits_manager_id;
    logic        io_busy;

    grant_finish_unit #(.DEPTH(DEPTH), .BEATS(BEATS)) dut (
        .clk(clk),
        .reset(reset),
        .io_in_grant_valid(io_in_grant_valid),
        .io_in_grant_ready(io_in_grant_ready),
        .io_in_grant_bits_addr_beat(io_in_grant_bits_addr_beat),
        .io_in_grant_bits_client_xact_id(io_in_grant_bits_client_xact_id),
        .io_in_grant_bits_manager_xact_id(io_in_grant_bits_manager_xact_id),
        .io_in_grant_bits_is_builtin_type(io_in_grant_bits_is_builtin_type),
        .io_in_grant_bits_g_type(io_in_grant_bits_g_type),
        .io_in_grant_bits_data(io_in_grant_bits_data),
        .io_in_grant_bits_manager_id(io_in_grant_bits_manager_id),
        .io_out_grant_valid(io_out_grant_valid),
        .io_out_grant_ready(io_out_grant_ready),
        .io_out_grant_bits_addr_beat(io_out_grant_bits_addr_beat),
        .io_out_grant_bits_client_xact_id(io_out_grant_bits_client_xact_id),
        .io_out_grant_bits_manager_xact_id(io_out_grant_bits_manager_xact_id),
        .io_out_grant_bits_is_builtin_type(io_out_grant_bits_is_builtin_type),
        .io_out_grant_bits_g_type(io_out_grant_bits_g_type),
        .io_out_grant_bits_data(io_out_grant_bits_data),
        .io_out_grant_bits_manager_id(io_out_grant_bits_manager_id),
        .io_finish_valid(io_finish_valid),
        .io_finish_ready(io_finish_ready),
        .io_finish_bits_manager_xact_id(io_finish_bits_manager_xact_id),
        .io_finish_bits_manager_id(io_finish_bits_manager_id),
        .io_busy(io_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: beats already taken in the current burst, pending finishes
    int       beats_done = 0;
    bit [1:0] fq[$];

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, check combinational outputs, then advance the model at the edge
    task automatic cycle(input bit rst, input bit iv, input bit bi, input bit [3:0] gt,
                         input bit mx, input bit mid, input bit ordy, input bit frdy);
        bit mb, nf, last, stl, exp_rdy, fire, fv;
        bit [79:0] fwd_in;
        reset                            = rst;
        io_in_grant_valid                = iv;
        io_in_grant_bits_addr_beat       = 3'($urandom);
        io_in_grant_bits_client_xact_id  = 2'($urandom);
        io_in_grant_bits_manager_xact_id = mx;
        io_in_grant_bits_is_builtin_type = bi;
        io_in_grant_bits_g_type          = gt;
        io_in_grant_bits_data            = {32'($urandom), 32'($urandom)};
        io_in_grant_bits_manager_id      = mid;
        io_out_grant_ready               = ordy;
        io_finish_ready                  = frdy;
        #1;
        mb      = bi ? (gt == 5) : (gt <= 1);
        nf      = !(bi && gt == 0);
        last    = !mb || (beats_done == BEATS - 1);
        stl     = !rst && nf && last && (fq.size() == DEPTH);
        exp_rdy = ordy && !stl;
        fire    = iv && exp_rdy;
        fv      = !rst && (fq.size() != 0);
        fwd_in  = {4'h0, io_in_grant_bits_addr_beat, io_in_grant_bits_client_xact_id, mx, bi, gt,
                   io_in_grant_bits_data, mid};
        check("out_valid", 80'(io_out_grant_valid), 80'(iv && !stl));
        check("in_ready", 80'(io_in_grant_ready), 80'(exp_rdy));
        check("fwd_bits", {4'h0, io_out_grant_bits_addr_beat, io_out_grant_bits_client_xact_id,
                           io_out_grant_bits_manager_xact_id, io_out_grant_bits_is_builtin_type,
                           io_out_grant_bits_g_type, io_out_grant_bits_data,
                           io_out_grant_bits_manager_id}, fwd_in);
        check("finish_valid", 80'(io_finish_valid), 80'(fv));
        if (fv) begin
            check("finish_bits", 80'({io_finish_bits_manager_xact_id, io_finish_bits_manager_id}),
                  80'(fq[0]));
        end
        check("busy", 80'(io_busy), 80'(!rst && (beats_done != 0 || fq.size() != 0)));
        @(posedge clk);
        if (rst) begin
            beats_done = 0;
            fq.delete();
        end else begin
            if (fv && frdy) void'(fq.pop_front());
            if (fire && nf && last) fq.push_back({mx, mid});
            if (fire && mb) beats_done = (beats_done + 1) % BEATS;
        end
        #1;
    endtask

    initial begin
        // Reset with a grant offered: path stays combinational
        cycle(1, 1, 1, 4'd3, 1, 1, 1, 1);
        cycle(1, 0, 0, 4'd0, 0, 0, 1, 1);
        check("rst_fv", 80'(io_finish_valid), 80'(0));

        // Single-beat finish grant
        cycle(0, 1, 1, 4'd3, 1, 0, 1, 0);
        check("single_fv", 80'(io_finish_valid), 80'(1));
        check("single_bits", 80'({io_finish_bits_manager_xact_id, io_finish_bits_manager_id}), 80'(2'b10));
        cycle(0, 0, 0, 4'd0, 0, 0, 1, 1);
        check("single_drained", 80'(io_finish_valid), 80'(0));

        // Eight-beat burst yields one finish only after the last beat
        for (int i = 0; i < 8; i++) begin
            cycle(0, 1, 0, 4'd0, 0, 1, 1, 0);
            if (i == 6) check("burst_mid_fv", 80'(io_finish_valid), 80'(0));
        end
        check("burst_fv", 80'(io_finish_valid), 80'(1));
        check("burst_bits", 80'({io_finish_bits_manager_xact_id, io_finish_bits_manager_id}), 80'(2'b01));
        cycle(0, 0, 0, 4'd0, 0, 0, 1, 1);
        check("burst_one_entry", 80'(io_finish_valid), 80'(0));

        // Voluntary ack needs no finish
        cycle(0, 1, 1, 4'd0, 1, 1, 1, 0);
        check("vack_fv", 80'(io_finish_valid), 80'(0));
        check("vack_busy", 80'(io_busy), 80'(0));

        // Full queue stalls a third finish grant even while a finish is dequeued
        cycle(0, 1, 1, 4'd3, 0, 0, 1, 0);
        cycle(0, 1, 1, 4'd4, 1, 1, 1, 0);
        cycle(0, 1, 1, 4'd3, 1, 0, 1, 0);
        cycle(0, 1, 1, 4'd3, 1, 0, 1, 1);
        check("full_next_ready", 80'(io_in_grant_ready), 80'(1));
        cycle(0, 1, 1, 4'd3, 1, 0, 1, 0);
        for (int i = 0; i < 2; i++) cycle(0, 0, 0, 4'd0, 0, 0, 1, 1);
        check("full_drained", 80'(io_finish_valid), 80'(0));

        // Reset mid-burst restarts the burst
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 4'd1, 1, 1, 1, 1);
        check("mid_busy", 80'(io_busy), 80'(1));
        cycle(1, 0, 0, 4'd0, 0, 0, 1, 1);
        cycle(0, 0, 0, 4'd0, 0, 0, 1, 1);
        check("rst_busy", 80'(io_busy), 80'(0));
        for (int i = 0; i < 8; i++) begin
            cycle(0, 1, 0, 4'd1, 1, 1, 1, 0);
            if (i == 6) check("rst_burst_mid", 80'(io_finish_valid), 80'(0));
        end
        check("rst_burst_fv", 80'(io_finish_valid), 80'(1));
        cycle(0, 0, 0, 4'd0, 0, 0, 1, 1);

        // Backpressure: nothing fires
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 4'd0, 0, 0, 0, 0);
        check("bp_busy", 80'(io_busy), 80'(0));

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(99) == 0), ($urandom_range(3) != 0), 1'($urandom),
                  4'($urandom_range(6)), 1'($urandom), 1'($urandom),
                  ($urandom_range(4) != 0), ($urandom_range(2) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/grant_finish_unit.md
GRANT_FINISH_UNIT -- requirements
Module: grant_finish_unit

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
  - DEPTH, 2, finish queue entries, 1..4
  - BEATS, 8, beats per multibeat grant, power of two
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
  - clk, in, 1, sole clock; all state on rising edge
  - reset, in, 1, synchronous, active-high
  - io_in_grant_valid, in, 1, grant beat from outer manager
  - io_in_grant_ready, out, 1, beat accepted
  - io_in_grant_bits_addr_beat, in, 3, beat index
  - io_in_grant_bits_client_xact_id, in, 2, {client_id, client_xact_id}
  - io_in_grant_bits_manager_xact_id, in, 1, manager transaction id
  - io_in_grant_bits_is_builtin_type, in, 1, built-in grant
  - io_in_grant_bits_g_type, in, 4, grant type
  - io_in_grant_bits_data, in, 64, beat data
  - io_in_grant_bits_manager_id, in, 1, issuing manager
  - io_out_grant_valid / _ready, out / in, 1 each, grant toward the stateless bridge outer grant port
  - io_out_grant_bits_*, out, same widths as io_in_grant_bits_*, forwarded fields
  - io_finish_valid, out, 1, finish message pending
  - io_finish_ready, in, 1, finish accepted
  - io_finish_bits_manager_xact_id, out, 1, id being finished
  - io_finish_bits_manager_id, out, 1, manager being finished
  - io_busy, out, 1, burst in progress or queue non-empty
REQ-003 Clock port SHALL be named clk and reset port reset; reset is synchronous and active-high.

Function
REQ-004 Grant path SHALL be combinational pass-through: io_out_grant_bits_* = io_in_grant_bits_*; zero latency.
REQ-005 io_out_grant_valid SHALL equal io_in_grant_valid AND NOT stall; io_in_grant_ready SHALL equal io_out_grant_ready AND NOT stall.
REQ-006 Beat fires when io_in_grant_valid AND io_in_grant_ready.
REQ-007 multibeat = (!is_builtin_type AND g_type<=1) OR (is_builtin_type AND g_type==5).
REQ-008 needs_finish = !is_builtin_type OR g_type!=0 (built-in type 0 voluntaryAck needs none).
REQ-009 Beat counter (log2 BEATS bits) SHALL increment on each fired multibeat beat and wrap from BEATS-1 to 0; single-beat grants do not touch it.
REQ-010 last_beat = !multibeat OR counter==BEATS-1.
REQ-011 enq = fire AND needs_finish AND last_beat; queue entry = {manager_xact_id, manager_id}.
REQ-012 stall = needs_finish AND last_beat AND queue full (count==DEPTH); a simultaneous dequeue SHALL NOT lift the stall.
REQ-013 Queue SHALL be FIFO, order preserved; io_finish_valid = count!=0; io_finish_bits_* = head entry.
REQ-014 Dequeue on io_finish_valid AND io_finish_ready; simultaneous enq and deq with 0<count<DEPTH SHALL leave count unchanged.
REQ-015 Non-last beats and non-finish grants SHALL never stall.
REQ-016 io_busy = (counter!=0) OR (count!=0).
REQ-017 Counter SHALL NOT depend on addr_beat; addr_beat is forwarded only.

Reset
REQ-018 On reset high at a clock edge: counter=0, count=0, read/write pointers=0; in-flight burst discarded.
REQ-019 During and after reset: io_finish_valid=0, io_busy=0; grant path still combinational, stall=0.
REQ-020 Reset mid-burst SHALL make the next fired multibeat beat beat 0 of a new burst.

Verification
REQ-021 Single beat: builtin g_type=3, mgr_xact=1, mgr_id=0, out_ready=1 -> passed same cycle; next cycle io_finish_valid=1 with {1,0}.
REQ-022 Burst: 8 beats !builtin g_type=0 mgr_xact=0 -> finish_valid stays 0 until cycle after beat 7; exactly one entry.
REQ-023 VoluntaryAck: builtin g_type=0 -> forwarded, finish_valid stays 0, io_busy 0.
REQ-024 Full queue: finish_ready=0, two finish grants enqueued, third offered -> io_in_grant_ready=0, io_out_grant_valid=0 until a finish fires; then accepted next cycle.
REQ-025 Reset after 3 beats of a burst -> counter 0, io_busy 0; new 8-beat burst yields one finish after its 8th beat.
REQ-026 Backpressure: out_ready=0 with in_valid=1 -> no fire, counter and queue unchanged.
